// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, load/store funct3 codes, MEM stage
// state encoding and the store-side lane helpers.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Legal funct3 for the direction, and natural alignment for the access size
  function automatic logic access_legal(input logic is_load, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic f3_ok;
    logic align_ok;
    case (f3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = is_load;
      default:          f3_ok = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   align_ok = ~a[0];
      2'b10:   align_ok = (a == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return f3_ok & align_ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select plus sign/zero extension; purely combinational so any
// cache or LSU can drop it in after its own read register.
module load_extend
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result_c
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    result_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result_c = {24'h0, shifted[7:0]};
      F3_HU:   result_c = {16'h0, shifted[15:0]};
      default: result_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: issues loads/stores over a req/ready port and registers
// the writeback result. Define MEM_TIMEOUT_EN to bound the WAIT state.
module mem_access_stage #(
  parameter int unsigned XLEN           = rv32i_pkg::XLEN,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic [XLEN-1:0] writedata_out,
  output logic [4:0]      rw_out,
  output logic            valid_out,
  output logic            misalign_err
);
  import rv32i_pkg::*;

  mem_state_t      state, state_n;
  logic [4:0]      rd_q, rd_n;
  logic [2:0]      f3_q, f3_n;
  logic [1:0]      a_q, a_n;
  logic            ld_q, ld_n;
  logic [XLEN-1:0] wd_n, addr_n, wdata_n, load_c;
  logic [4:0]      rw_n;
  logic [3:0]      be_n;
  logic            vo_n, req_n, we_n, err_n, legal_c;

  load_extend u_load_extend (
    .rdata    (dmem_rdata),
    .addr_lo  (a_q),
    .funct3   (f3_q),
    .result_c (load_c)
  );

  assign stall_out = (state == WAIT);
  assign legal_c   = access_legal(mem_read, funct3, alu_result[1:0]) & ~(mem_read & mem_write);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counts cycles spent in WAIT; held at zero while IDLE so each entry starts fresh
  always_ff @(posedge clk) begin
    if (!reset)              tmo_cnt <= '0;
    else if (state == IDLE)  tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + CNT_W'(1);
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    wd_n    = writedata_out;
    rw_n    = rw_out;
    vo_n    = 1'b0;
    req_n   = dmem_req;
    we_n    = dmem_we;
    addr_n  = dmem_addr;
    be_n    = dmem_be;
    wdata_n = dmem_wdata;
    err_n   = 1'b0;
    rd_n    = rd_q;
    f3_n    = f3_q;
    a_n     = a_q;
    ld_n    = ld_q;
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (!mem_read && !mem_write) begin
            wd_n = alu_result;
            rw_n = rd_in;
            vo_n = 1'b1;
          end else if (!legal_c) begin
            err_n = 1'b1;
            rw_n  = 5'd0;
            wd_n  = '0;
            vo_n  = 1'b1;
          end else begin
            rd_n    = rd_in;
            f3_n    = funct3;
            a_n     = alu_result[1:0];
            ld_n    = mem_read;
            req_n   = 1'b1;
            we_n    = mem_write;
            addr_n  = {alu_result[XLEN-1:2], 2'b00};
            be_n    = byte_en(funct3, alu_result[1:0]);
            wdata_n = store_lanes(funct3, store_data);
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          req_n   = 1'b0;
          we_n    = 1'b0;
          vo_n    = 1'b1;
          state_n = IDLE;
          wd_n    = ld_q ? load_c : '0;
          rw_n    = ld_q ? rd_q : 5'd0;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_n   = 1'b0;
          we_n    = 1'b0;
          err_n   = 1'b1;
          rw_n    = 5'd0;
          wd_n    = '0;
          vo_n    = 1'b1;
          state_n = IDLE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      writedata_out <= '0;
      rw_out        <= 5'd0;
      valid_out     <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= 4'b0000;
      dmem_wdata    <= '0;
      misalign_err  <= 1'b0;
      rd_q          <= 5'd0;
      f3_q          <= 3'b000;
      a_q           <= 2'b00;
      ld_q          <= 1'b0;
    end else begin
      writedata_out <= wd_n;
      rw_out        <= rw_n;
      valid_out     <= vo_n;
      dmem_req      <= req_n;
      dmem_we       <= we_n;
      dmem_addr     <= addr_n;
      dmem_be       <= be_n;
      dmem_wdata    <= wdata_n;
      misalign_err  <= err_n;
      rd_q          <= rd_n;
      f3_q          <= f3_n;
      a_q           <= a_n;
      ld_q          <= ld_n;
    end
  end

endmodule
